// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus TX FIFO, status and cycle-counter I/O window for the MIPS data port
module dmem_mmio #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] wdata_i32,
  output logic [31:0] rdata_o32,
  output logic [31:0] tx_data_o32,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [31:0] cycle, status;
  logic [AW-1:0] idx;
  logic io_sel, wr_tx, wr_st, wr_cy, full, empty, push, pop, ovf;
  assign idx = addr_i32[AW+1:2];
  assign io_sel = addr_i32[31:16] == 16'hFFFF;
  assign wr_tx = we_i && io_sel && addr_i32[15:0] == 16'h0000;
  assign wr_st = we_i && io_sel && addr_i32[15:0] == 16'h0004;
  assign wr_cy = we_i && io_sel && addr_i32[15:0] == 16'h0008;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_valid_o = !empty;
  assign tx_data_o32 = fifo[rd_ptr];
  assign pop = tx_valid_o && tx_ready_i;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push = wr_tx && (!full || pop);
  assign status = {20'b0, 4'(count), 5'b0, ovf, empty, full};
  always_comb
    rdata_o32 = !io_sel ? ram[idx] :
                addr_i32[15:0] == 16'h0004 ? status :
                addr_i32[15:0] == 16'h0008 ? cycle : 32'h0;
  always_ff @(posedge clk_i) begin
    if (we_i && !io_sel) ram[idx] <= wdata_i32;
    if (push) fifo[wr_ptr] <= wdata_i32;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      cycle <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      ovf <= (wr_tx && !push) ? 1'b1 : (wr_st && wdata_i32[2]) ? 1'b0 : ovf;
      cycle <= wr_cy ? wdata_i32 : cycle + 32'd1;
    end
endmodule
